// File: rtl/rv_core_pkg.sv
// Shared types, opcode/funct3 constants and datapath helpers for the rv_core pipeline.
package rv_core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;
  localparam int unsigned IA_W   = 16;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP       = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd_a;
    logic [XLEN-1:0]   rd_d;
  } stage_buf_t;

  // Integer ALU shared by OP and OP-IMM; shifts use only the low 5 bits of b.
  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic sub,
                                          input logic sra, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [4:0]      sh;
    sh = b[4:0];
    r  = '0;
    case (f3)
      F3_ADD:  r = sub ? a - b : a + b;
      F3_SLL:  r = a << sh;
      F3_SLT:  r = XLEN'($signed(a) < $signed(b));
      F3_SLTU: r = XLEN'(a < b);
      F3_XOR:  r = a ^ b;
      F3_SR:   r = sra ? XLEN'($signed(a) >>> sh) : a >> sh;
      F3_OR:   r = a | b;
      F3_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Youngest matching in-flight result wins; x0 is hard zero.
  function automatic logic [XLEN-1:0] bypass(input logic [REG_AW-1:0] a,
                                             input logic [XLEN-1:0] rf_d,
                                             input stage_buf_t b0, input stage_buf_t b1,
                                             input stage_buf_t b2);
    logic [XLEN-1:0] d;
    d = rf_d;
    if (a == '0)                        d = '0;
    else if (b0.we && (b0.rd_a == a))   d = b0.rd_d;
    else if (b1.we && (b1.rd_a == a))   d = b1.rd_d;
    else if (b2.we && (b2.rd_a == a))   d = b2.rd_d;
    return d;
  endfunction

endpackage

// File: rtl/rv_core_exe.sv
// Decode, bypass and ALU for the IR instruction, plus the EXE/CSR/LSU result buffers.
module rv_core_exe
  import rv_core_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_v,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_ins,
  output logic [REG_AW-1:0] o_rs1_a,
  output logic [REG_AW-1:0] o_rs2_a,
  input  logic [XLEN-1:0]   i_rs1_d,
  input  logic [XLEN-1:0]   i_rs2_d,
  output logic              o_rd_e,
  output logic [REG_AW-1:0] o_rd_a,
  output logic [XLEN-1:0]   o_rd_d
);

  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [2:0]        w_f3;
  logic              w_alt;
  logic [XLEN-1:0]   w_iimm;
  logic [XLEN-1:0]   w_uimm;
  logic [XLEN-1:0]   w_rs1_d;
  logic [XLEN-1:0]   w_rs2_d;
  logic [XLEN-1:0]   w_res;
  logic              w_we;
  logic              buf0_we;

  stage_buf_t r_buf0;
  stage_buf_t r_buf1;
  stage_buf_t r_buf2;

  assign w_opcode = i_ins[6:0];
  assign w_rd     = i_ins[11:7];
  assign w_f3     = i_ins[14:12];
  assign w_rs1    = i_ins[19:15];
  assign w_rs2    = i_ins[24:20];
  assign w_alt    = i_ins[30];
  assign w_iimm   = {{20{i_ins[31]}}, i_ins[31:20]};
  assign w_uimm   = {i_ins[31:12], 12'h000};

  assign o_rs1_a  = w_rs1;
  assign o_rs2_a  = w_rs2;
  assign w_rs1_d  = bypass(w_rs1, i_rs1_d, r_buf0, r_buf1, r_buf2);
  assign w_rs2_d  = bypass(w_rs2, i_rs2_d, r_buf0, r_buf1, r_buf2);

  always_comb begin
    w_res = '0;
    w_we  = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_res = w_uimm;
        w_we  = 1'b1;
      end
      OP_AUIPC: begin
        w_res = i_pc + w_uimm;
        w_we  = 1'b1;
      end
      OP_IMM: begin
        // ins[30] is an immediate bit for ADDI, so it only selects arithmetic shift here.
        w_res = alu(w_f3, 1'b0, w_alt, w_rs1_d, w_iimm);
        w_we  = 1'b1;
      end
      OP: begin
        w_res = alu(w_f3, w_alt, w_alt, w_rs1_d, w_rs2_d);
        w_we  = 1'b1;
      end
      default: begin
        w_res = '0;
        w_we  = 1'b0;
      end
    endcase
    if (!i_v || (w_rd == '0)) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_buf2 <= '0;
    end else begin
      r_buf0 <= '{we: w_we, rd_a: w_rd, rd_d: w_res};
      r_buf1 <= r_buf0;
      r_buf2 <= r_buf1;
    end
  end

  assign buf0_we = r_buf0.we;
  assign o_rd_e  = r_buf2.we;
  assign o_rd_a  = r_buf2.rd_a;
  assign o_rd_d  = r_buf2.rd_d;

endmodule

// File: rtl/rv_core_ifu.sv
// Fetch unit: PC sequencing, SRAM request tracking and the IR stage.
module rv_core_ifu
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [IA_W-1:0] o_ins_a,
  output logic            o_ins_e,
  input  logic [XLEN-1:0] i_ins,
  output logic            o_ifu_v,
  output logic [XLEN-1:0] o_ifu_pc,
  output logic [XLEN-1:0] o_ifu_ins
);

  logic [XLEN-1:0] pc;
  logic            r_ins_e;
  logic            r_req_v;
  logic [XLEN-1:0] r_req_pc;
  logic            r_ifu_v;
  logic [XLEN-1:0] r_ifu_pc;
  logic [XLEN-1:0] r_ifu_ins;

  // The SRAM answers one cycle after the request edge, so the request pc is kept alongside it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc        <= RESET_PC;
      r_ins_e   <= 1'b0;
      r_req_v   <= 1'b0;
      r_req_pc  <= RESET_PC;
      r_ifu_v   <= 1'b0;
      r_ifu_pc  <= '0;
      r_ifu_ins <= '0;
    end else begin
      r_ins_e <= 1'b1;
      r_req_v <= r_ins_e;
      if (r_ins_e) begin
        pc       <= pc + XLEN'(4);
        r_req_pc <= pc;
      end
      r_ifu_v   <= r_req_v;
      r_ifu_pc  <= r_req_v ? r_req_pc : '0;
      r_ifu_ins <= r_req_v ? i_ins : '0;
    end
  end

  assign o_ins_a   = pc[IA_W-1:0];
  assign o_ins_e   = r_ins_e;
  assign o_ifu_v   = r_ifu_v;
  assign o_ifu_pc  = r_ifu_pc;
  assign o_ifu_ins = r_ifu_ins;

endmodule

// File: rtl/rv_core_rf.sv
// 32x32 integer register file: two combinational read ports, one commit write port.
module rv_core_rf
  import rv_core_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] i_rs1_a,
  input  logic [REG_AW-1:0] i_rs2_a,
  output logic [XLEN-1:0]   o_rs1_d,
  output logic [XLEN-1:0]   o_rs2_d,
  input  logic              rd_e,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [XLEN-1:0]   rd_d
);

  logic [XLEN-1:0] rf_arr [0:NREG-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREG; i++) rf_arr[REG_AW'(i)] <= '0;
    end else if (rd_e && (rd_a != '0)) begin
      rf_arr[rd_a] <= rd_d;
    end
  end

  assign o_rs1_d = rf_arr[i_rs1_a];
  assign o_rs2_d = rf_arr[i_rs2_a];

endmodule

// File: rtl/rv_core.sv
// rv_core top: 7-stage in-order RV32I integer pipeline; data port tied off.
module rv_core
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [IA_W-1:0] ins_a,
  output logic            ins_e,
  input  logic [XLEN-1:0] ins,
  output logic [IA_W-1:0] dat_a,
  output logic [3:0]      dat_we,
  output logic [XLEN-1:0] dat_wd,
  output logic            dat_re,
  input  logic [XLEN-1:0] dat_rd
);

  logic              ifu_v;
  logic [XLEN-1:0]   ifu_pc;
  logic [XLEN-1:0]   ifu_ins;
  logic [REG_AW-1:0] w_rs1_a;
  logic [REG_AW-1:0] w_rs2_a;
  logic [XLEN-1:0]   w_rs1_d;
  logic [XLEN-1:0]   w_rs2_d;
  logic              w_rd_e;
  logic [REG_AW-1:0] w_rd_a;
  logic [XLEN-1:0]   w_rd_d;
  logic              w_unused_dat;

  rv_core_ifu #(.RESET_PC(RESET_PC)) u_ifu0 (
    .clk       (clk),
    .rstn      (rstn),
    .o_ins_a   (ins_a),
    .o_ins_e   (ins_e),
    .i_ins     (ins),
    .o_ifu_v   (ifu_v),
    .o_ifu_pc  (ifu_pc),
    .o_ifu_ins (ifu_ins)
  );

  rv_core_exe u_exe0 (
    .clk     (clk),
    .rstn    (rstn),
    .i_v     (ifu_v),
    .i_pc    (ifu_pc),
    .i_ins   (ifu_ins),
    .o_rs1_a (w_rs1_a),
    .o_rs2_a (w_rs2_a),
    .i_rs1_d (w_rs1_d),
    .i_rs2_d (w_rs2_d),
    .o_rd_e  (w_rd_e),
    .o_rd_a  (w_rd_a),
    .o_rd_d  (w_rd_d)
  );

  rv_core_rf u_rf0 (
    .clk     (clk),
    .rstn    (rstn),
    .i_rs1_a (w_rs1_a),
    .i_rs2_a (w_rs2_a),
    .o_rs1_d (w_rs1_d),
    .o_rs2_d (w_rs2_d),
    .rd_e    (w_rd_e),
    .rd_a    (w_rd_a),
    .rd_d    (w_rd_d)
  );

  // Data port is reserved for the load/store revision.
  assign dat_a        = '0;
  assign dat_we       = '0;
  assign dat_wd       = '0;
  assign dat_re       = 1'b0;
  assign w_unused_dat = ^dat_rd;

endmodule

// File: tb/tb_rv_core.sv
// Directed self-checking bench for rv_core with a 1-cycle-latency instruction SRAM model.
module tb_rv_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins = 32'h0;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic        dat_re;
  logic [31:0] dat_rd = 32'hDEAD_BEEF;

  logic [31:0] imem [0:63];
  logic [31:0] exp2 [0:14];
  int n_tests = 0;
  int n_fail  = 0;

  rv_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .ins_a  (ins_a),
    .ins_e  (ins_e),
    .ins    (ins),
    .dat_a  (dat_a),
    .dat_we (dat_we),
    .dat_wd (dat_wd),
    .dat_re (dat_re),
    .dat_rd (dat_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ins_e) ins <= imem[ins_a[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    edges(2);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic check_dat(input string tag);
    chk(tag, 32'(|{dat_a, dat_we, dat_wd, dat_re}), 32'h0);
  endtask

  task automatic load_prog2();
    clear_imem();
    imem[0]  = 32'h0010_0093; exp2[1]  = 32'h0000_0001; // ADDI x1,x0,1
    imem[1]  = 32'h0020_8113; exp2[2]  = 32'h0000_0003; // ADDI x2,x1,2
    imem[2]  = 32'h0011_01B3; exp2[3]  = 32'h0000_0004; // ADD  x3,x2,x1
    imem[3]  = 32'h4030_8233; exp2[4]  = 32'hFFFF_FFFD; // SUB  x4,x1,x3
    imem[4]  = 32'h4012_5293; exp2[5]  = 32'hFFFF_FFFE; // SRAI x5,x4,1
    imem[5]  = 32'h01C2_5313; exp2[6]  = 32'h0000_000F; // SRLI x6,x4,28
    imem[6]  = 32'h0012_23B3; exp2[7]  = 32'h0000_0001; // SLT  x7,x4,x1
    imem[7]  = 32'h0012_3433; exp2[8]  = 32'h0000_0000; // SLTU x8,x4,x1
    imem[8]  = 32'hFFF1_C493; exp2[9]  = 32'hFFFF_FFFB; // XORI x9,x3,-1
    imem[9]  = 32'h0031_1533; exp2[10] = 32'h0000_0030; // SLL  x10,x2,x3
    imem[10] = 32'h0F04_F593; exp2[11] = 32'h0000_00F0; // ANDI x11,x9,0xF0
    imem[11] = 32'h7000_E613; exp2[12] = 32'h0000_0701; // ORI  x12,x1,0x700
    imem[12] = 32'hFFF0_B693; exp2[13] = 32'h0000_0001; // SLTIU x13,x1,-1
    imem[13] = 32'h4032_5733; exp2[14] = 32'hFFFF_FFFF; // SRA  x14,x4,x3
    exp2[0] = 32'h0;
  endtask

  task automatic check_prog2(input string tag);
    for (int r = 0; r <= 14; r++)
      chk($sformatf("%s_x%0d", tag, r), dut.u_rf0.rf_arr[r], exp2[r]);
  endtask

  initial begin
    // Reset state and fetch sequence, single ADDI latency.
    clear_imem();
    imem[0] = 32'h0050_0093; // ADDI x1,x0,5
    rstn = 1'b0;
    edges(2);
    chk("rst_pc", dut.u_ifu0.pc, 32'h0);
    chk("rst_ins_e", 32'(ins_e), 32'h0);
    chk("rst_ins_a", 32'(ins_a), 32'h0);
    chk("rst_rd_e", 32'(dut.u_rf0.rd_e), 32'h0);
    chk("rst_ifu_ins", dut.ifu_ins, 32'h0);
    check_dat("rst_dat");
    @(negedge clk);
    rstn = 1'b1;
    edges(1);
    chk("e0_ins_e", 32'(ins_e), 32'h1);
    chk("e0_ins_a", 32'(ins_a), 32'h0);
    edges(1);
    chk("e1_ins_a", 32'(ins_a), 32'h4);
    edges(1);
    chk("e2_ins_a", 32'(ins_a), 32'h8);
    chk("e2_ifu_ins", dut.ifu_ins, 32'h0050_0093);
    chk("e2_ifu_pc", dut.ifu_pc, 32'h0);
    edges(1);
    chk("e3_ins_a", 32'(ins_a), 32'hC);
    chk("e3_buf0_we", 32'(dut.u_exe0.buf0_we), 32'h1);
    edges(1);
    chk("e4_rd_e", 32'(dut.u_rf0.rd_e), 32'h0);
    edges(1);
    chk("e5_rd_e", 32'(dut.u_rf0.rd_e), 32'h1);
    chk("e5_rd_a", 32'(dut.u_rf0.rd_a), 32'h1);
    chk("e5_x1_pre", dut.u_rf0.rf_arr[1], 32'h0);
    edges(1);
    chk("e6_x1", dut.u_rf0.rf_arr[1], 32'h5);
    check_dat("e6_dat");

    // Dependent chain through every bypass level and the ALU ops.
    load_prog2();
    do_reset();
    chk("rst2_x1", dut.u_rf0.rf_arr[1], 32'h0);
    edges(26);
    check_prog2("p2");
    check_dat("p2_dat");

    // AUIPC/LUI, writes to x0 and an undefined opcode.
    clear_imem();
    imem[1] = 32'h1234_5297; // AUIPC x5,0x12345
    imem[2] = 32'hFFFF_F337; // LUI   x6,0xFFFFF
    imem[3] = 32'h0070_0013; // ADDI  x0,x0,7
    imem[4] = 32'h0000_007F; // undefined
    do_reset();
    chk("rst3_x14", dut.u_rf0.rf_arr[14], 32'h0);
    edges(7);
    chk("p3_auipc_rd_e", 32'(dut.u_rf0.rd_e), 32'h1);
    chk("p3_auipc_rd_a", 32'(dut.u_rf0.rd_a), 32'h5);
    edges(1);
    chk("p3_lui_rd_e", 32'(dut.u_rf0.rd_e), 32'h1);
    chk("p3_lui_rd_a", 32'(dut.u_rf0.rd_a), 32'h6);
    edges(1);
    chk("p3_x0_rd_e", 32'(dut.u_rf0.rd_e), 32'h0);
    edges(1);
    chk("p3_undef_rd_e", 32'(dut.u_rf0.rd_e), 32'h0);
    edges(3);
    chk("p3_x5", dut.u_rf0.rf_arr[5], 32'h1234_5004);
    chk("p3_x6", dut.u_rf0.rf_arr[6], 32'hFFFF_F000);
    chk("p3_x0", dut.u_rf0.rf_arr[0], 32'h0);

    // One-cycle reset after five fetches discards in-flight work and replays identically.
    load_prog2();
    do_reset();
    edges(6);
    chk("p4_pending_rd_e", 32'(dut.u_rf0.rd_e), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    edges(1);
    chk("p4_x1_dropped", dut.u_rf0.rf_arr[1], 32'h0);
    chk("p4_pc", dut.u_ifu0.pc, 32'h0);
    chk("p4_ins_e", 32'(ins_e), 32'h0);
    chk("p4_rd_e", 32'(dut.u_rf0.rd_e), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    edges(1);
    chk("p4_e0_ins_a", 32'(ins_a), 32'h0);
    chk("p4_e0_ins_e", 32'(ins_e), 32'h1);
    edges(1);
    chk("p4_e1_ins_a", 32'(ins_a), 32'h4);
    edges(24);
    check_prog2("p4");
    check_dat("p4_dat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_core.md
Name: rv_core

Overview:
- Minimal in-order RV32I integer core, 7-stage pipeline: PC, IMEM out, IR, EXE, CSR, LSU, COMMIT.
- Fetches from a synchronous instruction SRAM with 1-cycle read latency.
- Executes LUI, AUIPC, OP-IMM and OP instructions with full operand bypassing.
- Writes a 32x32 register file at commit. Data-memory port is reserved for the next revision and tied off.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- ins_a  out  16  instruction byte address (= pc[15:0]).
- ins_e  out  1  instruction fetch enable.
- ins  in  32  instruction word; valid the cycle after the edge that sampled ins_a/ins_e.
- dat_a  out  16  data byte address, reserved.
- dat_we  out  4  data byte write strobes, reserved.
- dat_wd  out  32  data write data, reserved.
- dat_re  out  1  data read enable, reserved.
- dat_rd  in  32  data read data, ignored.

Behaviour:
- Reset (rstn=0 at an edge):
  - pc=RESET_PC, ins_e=0.
  - All stage valids=0; IR=0 (NOP).
  - All register-file entries=0.
  - dat_* outputs are constant 0 at all times.
- Fetch:
  - Let E0 be the first edge with rstn=1. At E0, ins_e becomes 1 and pc stays RESET_PC.
  - At each later edge with ins_e=1: pc += 4, and the fetched pc is registered as the "request pc".
  - No stalls and no branches; the address sequence is 0, 4, 8, …
- IR stage: at E2 onward, ifu_ins <= ins and ifu_pc <= request pc, with a valid bit.
  - First instruction (pc 0) sits in IR after E2.
- EXE (combinational from IR, registered into buf0 at the next edge):
  - Decode rd, rs1, rs2, funct3, funct7 and I/U immediates (sign-extended per the ISA).
  - LUI: rd = uimm.
  - AUIPC: rd = ifu_pc + uimm.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (shamt = ins[24:20]; ins[30] selects SRAI).
  - OP: ADD/SUB (ins[30]), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - Any other opcode, or rd=0: write-enable (we) = 0, i.e. NOP.
  - All arithmetic is 32-bit and wraps; shifts use only the low 5 bits.
- Pipeline buffers:
  - buf0 (EXE out) → buf1 (CSR) → buf2 (LSU); each holds {we, rd_a, rd_d}. CSR and LSU pass through unchanged.
  - Commit: rd_e = buf2.we, rd_a = buf2.rd_a, rd_d = buf2.rd_d.
  - rf_arr[rd_a] <= rd_d at the next edge when rd_e=1 and rd_a≠0.
- Operand bypass for each source register (rs≠0), highest priority first: buf0, buf1, buf2 (only entries with we=1 and matching rd_a), then rf_arr. x0 always reads 0.
- Latency: the instruction at pc 0 has rd_e=1 after E5; the register file holds its result after E6. Throughput is 1 instruction per cycle.
- Reset mid-run: all in-flight instructions are discarded, no rf write on or after the reset edge, and fetch restarts from RESET_PC.
- Internal names are fixed for bench probing: u_ifu0.pc, ifu_pc, ifu_ins, u_exe0.buf0_we, u_rf0.rd_e, u_rf0.rd_a, u_rf0.rf_arr[0:31].

Decomposition:
- Package rv_core_pkg:
  - opcode constants: OP_LUI=0110111, OP_AUIPC=0010111, OP_IMM=0010011, OP=0110011.
  - funct3 constants.
  - typedef stage_buf_t {we, rd_a[4:0], rd_d[31:0]}.
- Sub-modules:
  - rv_core_ifu: pc, ins_e, IR.
  - rv_core_exe: decode, ALU, bypass, buf0..buf2.
  - rv_core_rf: 32x32 array, write port.

Test Plan:
- Reset release, observe ins_a → 0,0,4,8,… with ins_e=1 from E0; all dat_* stay 0.
- IMEM[0] = ADDI x1,x0,5 → rd_e=1, rd_a=1 after E5; rf_arr[1]=0x00000005 after E6.
- IMEM[0]=ADDI x1,x0,1; IMEM[4]=ADDI x2,x1,2; IMEM[8]=ADD x3,x2,x1 → x2=3, x3=4 (buf0 bypass).
- AUIPC x5,0x12345 at pc 0x4 → x5=0x12345004; LUI x6,0xFFFFF → x6=0xFFFFF000.
- ADDI x0,x0,7 and undefined opcode 0x0000007F → rd_e=0 for both; x0 remains 0.
- Assert rstn low for 1 cycle after 5 instructions are fetched → no pending writes land; fetch restarts at 0; result sequence repeats identically.
